// File: rtl/ttc_trigger_tagger.sv
//------------------------------------------------------------------------------
// ttc_trigger_tagger: tags each L1A with {trigger number, timestamp, fill type}
// and queues the tags in a first-word-fall-through FIFO for the readout.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ttc_trigger_tagger #(
  parameter int TS_WIDTH   = 44,
  parameter int TNUM_WIDTH = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int OVF_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_trigger,
  input  logic [1:0]                    i_fill_type,
  input  logic                          i_reset_trig_num,
  input  logic                          i_reset_trig_timestamp,
  output logic                          o_tag_valid,
  input  logic                          i_tag_ready,
  output logic [TNUM_WIDTH-1:0]         o_tag_trig_num,
  output logic [TS_WIDTH-1:0]           o_tag_timestamp,
  output logic [1:0]                    o_tag_fill_type,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic [OVF_WIDTH-1:0]          o_overflow_count,
  output logic                          o_error_overflow
);

  localparam int c_addr_w = $clog2(FIFO_DEPTH);
  localparam int c_tag_w  = TNUM_WIDTH + TS_WIDTH + 2;
  localparam logic [c_addr_w:0] c_depth = (c_addr_w+1)'(FIFO_DEPTH);

  logic [TS_WIDTH-1:0]   r_ts;
  logic [TNUM_WIDTH-1:0] r_trig_num;
  logic [c_tag_w-1:0]    r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0]   r_wr_ptr;
  logic [c_addr_w-1:0]   r_rd_ptr;
  logic [c_addr_w:0]     r_count;
  logic [OVF_WIDTH-1:0]  r_ovf_count;
  logic                  r_error_ovf;

  logic [TS_WIDTH-1:0]   w_ts_eff;
  logic [TNUM_WIDTH-1:0] w_base;
  logic [TNUM_WIDTH-1:0] w_tag_num;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [c_tag_w-1:0]    w_head;

  // Strobes zero their counter for the current cycle, so a coincident trigger sees 0.
  assign w_ts_eff  = i_reset_trig_timestamp ? '0 : r_ts;
  assign w_base    = i_reset_trig_num ? '0 : r_trig_num;
  assign w_tag_num = w_base + TNUM_WIDTH'(1);

  assign o_tag_valid = (r_count != '0);
  assign w_full      = (r_count == c_depth);
  assign w_pop       = o_tag_valid & i_tag_ready;
  // A pop frees the head slot in the same edge, so a full FIFO can still accept.
  assign w_push      = i_trigger & (~w_full | w_pop);
  assign w_drop      = i_trigger & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts        <= '0;
      r_trig_num  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ovf_count <= '0;
      r_error_ovf <= 1'b0;
    end else begin
      r_ts       <= w_ts_eff + TS_WIDTH'(1);
      // Dropped triggers still consume a number so the readout sees the gap.
      r_trig_num <= i_trigger ? w_tag_num : w_base;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_addr_w+1)'(1);
        2'b01:   r_count <= r_count - (c_addr_w+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_error_ovf <= 1'b1;
        if (r_ovf_count != '1) r_ovf_count <= r_ovf_count + OVF_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_tag_num, w_ts_eff, i_fill_type};
  end

  assign w_head           = r_mem[r_rd_ptr];
  assign o_tag_trig_num   = w_head[c_tag_w-1 -: TNUM_WIDTH];
  assign o_tag_timestamp  = w_head[TS_WIDTH+1 -: TS_WIDTH];
  assign o_tag_fill_type  = w_head[1:0];
  assign o_fifo_count     = r_count;
  assign o_overflow_count = r_ovf_count;
  assign o_error_overflow = r_error_ovf;

endmodule

`default_nettype wire

// File: tb/tb_ttc_trigger_tagger.sv
//------------------------------------------------------------------------------
// tb_ttc_trigger_tagger: directed checks of ttc_trigger_tagger, default build
// plus a narrow build (4-bit ts/tnum, depth 4, 2-bit overflow counter).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ttc_trigger_tagger;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        reset, trigger, rst_num, rst_ts, ready;
  logic [1:0]  fill;
  logic        m_valid, m_err;
  logic [23:0] m_num;
  logic [43:0] m_ts;
  logic [1:0]  m_fill;
  logic [4:0]  m_count;
  logic [15:0] m_ovf;

  ttc_trigger_tagger u_dut (
    .clk(clk), .reset(reset), .i_trigger(trigger), .i_fill_type(fill),
    .i_reset_trig_num(rst_num), .i_reset_trig_timestamp(rst_ts),
    .o_tag_valid(m_valid), .i_tag_ready(ready), .o_tag_trig_num(m_num),
    .o_tag_timestamp(m_ts), .o_tag_fill_type(m_fill), .o_fifo_count(m_count),
    .o_overflow_count(m_ovf), .o_error_overflow(m_err)
  );

  // Narrow instance for wrap and saturation corners
  logic        s_reset, s_trigger, s_ready;
  logic [1:0]  s_fill;
  logic        s_valid, s_err;
  logic [3:0]  s_num, s_ts;
  logic [1:0]  s_fill_o;
  logic [2:0]  s_count;
  logic [1:0]  s_ovf;

  ttc_trigger_tagger #(.TS_WIDTH(4), .TNUM_WIDTH(4), .FIFO_DEPTH(4), .OVF_WIDTH(2)) u_small (
    .clk(clk), .reset(s_reset), .i_trigger(s_trigger), .i_fill_type(s_fill),
    .i_reset_trig_num(1'b0), .i_reset_trig_timestamp(1'b0),
    .o_tag_valid(s_valid), .i_tag_ready(s_ready), .o_tag_trig_num(s_num),
    .o_tag_timestamp(s_ts), .o_tag_fill_type(s_fill_o), .o_fifo_count(s_count),
    .o_overflow_count(s_ovf), .o_error_overflow(s_err)
  );

  typedef struct {
    int          cyc;
    logic        trig;
    logic [1:0]  fill;
    logic        rn;
    logic        rt;
    logic [23:0] e_num;
    logic [43:0] e_ts;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic reset_main();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic reset_small();
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{10,  1'b1, 2'b01, 1'b0, 1'b0, 24'd1, 44'd10};
    vecs[1]  = '{11,  1'b1, 2'b01, 1'b0, 1'b0, 24'd2, 44'd11};
    vecs[2]  = '{20,  1'b1, 2'b01, 1'b0, 1'b0, 24'd3, 44'd20};
    vecs[3]  = '{30,  1'b1, 2'b10, 1'b0, 1'b0, 24'd4, 44'd30};
    vecs[4]  = '{31,  1'b1, 2'b11, 1'b0, 1'b0, 24'd5, 44'd31};
    vecs[5]  = '{40,  1'b1, 2'b00, 1'b1, 1'b0, 24'd1, 44'd40};
    vecs[6]  = '{41,  1'b1, 2'b10, 1'b0, 1'b0, 24'd2, 44'd41};
    vecs[7]  = '{60,  1'b0, 2'b00, 1'b1, 1'b0, 24'd0, 44'd0};
    vecs[8]  = '{62,  1'b1, 2'b01, 1'b0, 1'b0, 24'd1, 44'd62};
    vecs[9]  = '{100, 1'b1, 2'b01, 1'b0, 1'b1, 24'd2, 44'd0};
    vecs[10] = '{103, 1'b1, 2'b11, 1'b0, 1'b0, 24'd3, 44'd3};
    vecs[11] = '{104, 1'b0, 2'b00, 1'b0, 1'b1, 24'd0, 44'd0};
    vecs[12] = '{110, 1'b1, 2'b10, 1'b0, 1'b0, 24'd4, 44'd6};

    trigger = 1'b0; rst_num = 1'b0; rst_ts = 1'b0; ready = 1'b0; fill = 2'b00; reset = 1'b1;
    s_trigger = 1'b0; s_ready = 1'b0; s_fill = 2'b00; s_reset = 1'b1;

    // Reset state
    reset_main();
    chk("rst_valid", m_valid, 0);
    chk("rst_count", m_count, 0);
    chk("rst_ovf",   m_ovf, 0);
    chk("rst_err",   m_err, 0);

    // Table-driven tagging with the consumer always ready
    ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if (cyc < vecs[i].cyc) begin
        tick();
        chk("idle_valid", m_valid, 0);
      end
      while (cyc < vecs[i].cyc) tick();
      trigger = vecs[i].trig; fill = vecs[i].fill;
      rst_num = vecs[i].rn;   rst_ts = vecs[i].rt;
      tick();
      trigger = 1'b0; rst_num = 1'b0; rst_ts = 1'b0;
      if (vecs[i].trig) begin
        chk("vec_valid", m_valid, 1);
        chk("vec_num",   m_num, vecs[i].e_num);
        chk("vec_ts",    m_ts, vecs[i].e_ts);
        chk("vec_fill",  m_fill, vecs[i].fill);
        chk("vec_count", m_count, 1);
      end
    end
    chk("vec_err", m_err, 0);
    chk("vec_ovf", m_ovf, 0);

    // Overflow: 18 triggers into a 16-deep FIFO with no consumer
    reset_main();
    ready = 1'b0; fill = 2'b01;
    trigger = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    trigger = 1'b0;
    chk("ovf_count", m_count, 16);
    chk("ovf_ovf",   m_ovf, 2);
    chk("ovf_err",   m_err, 1);
    chk("ovf_head",  m_num, 1);
    tick();
    chk("hold_num", m_num, 1);
    chk("hold_ts",  m_ts, 0);

    // Full FIFO: trigger with a simultaneous pop is accepted
    trigger = 1'b1; ready = 1'b1;
    tick();
    trigger = 1'b0;
    chk("fullpp_count", m_count, 16);
    chk("fullpp_ovf",   m_ovf, 2);
    for (int k = 0; k < 16; k++) begin
      chk("drain_num", m_num, (k < 15) ? 64'(k + 2) : 64'd19);
      tick();
    end
    chk("drain_valid", m_valid, 0);
    chk("drain_count", m_count, 0);
    tick();
    chk("empty_ready_count", m_count, 0);
    chk("sticky_err", m_err, 1);

    // Reset with tags queued and a coincident trigger
    ready = 1'b0; trigger = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_count", m_count, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0; trigger = 1'b0; cyc = 0;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_count", m_count, 0);
    chk("mid_rst_ovf",   m_ovf, 0);
    chk("mid_rst_err",   m_err, 0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("post_rst_num", m_num, 1);
    chk("post_rst_ts",  m_ts, 0);
    chk("post_rst_cnt", m_count, 1);

    // Narrow build: timestamp wrap
    reset_small();
    s_ready = 1'b1; s_fill = 2'b10;
    for (int i = 0; i < 15; i++) tick();
    s_trigger = 1'b1;
    tick();
    chk("tswrap_ts15", s_ts, 15);
    chk("tswrap_num1", s_num, 1);
    chk("tswrap_fill", s_fill_o, 2'b10);
    tick();
    s_trigger = 1'b0;
    chk("tswrap_ts0",  s_ts, 0);
    chk("tswrap_num2", s_num, 2);

    // Narrow build: trigger-number wrap
    reset_small();
    s_trigger = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("tnwrap_num", s_num, 64'(i % 16));
    end
    s_trigger = 1'b0;

    // Narrow build: overflow counter saturates
    reset_small();
    s_ready = 1'b0; s_trigger = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    s_trigger = 1'b0;
    chk("sat_count", s_count, 4);
    chk("sat_ovf",   s_ovf, 3);
    chk("sat_err",   s_err, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ttc_trigger_tagger.md
Name: ttc_trigger_tagger

Overview:
- Sits directly downstream of the TTC Channel B receiver, in the trigger logic.
- Consumes the TTC L1A trigger pulse, the current fill type, and the trigger-number and timestamp reset strobes.
- Maintains a free-running timestamp counter and a trigger-number counter; on every L1A, builds a tag {trigger number, timestamp, fill type}.
- Tags are buffered in a first-word-fall-through FIFO and handed to the readout via a valid/ready handshake.

Parameters:
TS_WIDTH, 44, timestamp counter width in bits
TNUM_WIDTH, 24, trigger number width in bits
FIFO_DEPTH, 16, tag FIFO depth in entries; must be a power of 2, at least 2
OVF_WIDTH, 16, width of the overflow counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
trigger  in  1  L1A strobe, one cycle per trigger
fill_type  in  2  current fill type from the Channel B receiver
reset_trig_num  in  1  trigger-number reset strobe
reset_trig_timestamp  in  1  timestamp reset strobe
tag_valid  out  1  head-of-FIFO tag is valid
tag_ready  in  1  consumer accepts the head tag
tag_trig_num  out  TNUM_WIDTH  head tag trigger number
tag_timestamp  out  TS_WIDTH  head tag timestamp
tag_fill_type  out  2  head tag fill type
fifo_count  out  log2(FIFO_DEPTH)+1  current number of FIFO entries
overflow_count  out  OVF_WIDTH  number of triggers dropped because the FIFO was full; saturates
error_overflow  out  1  sticky flag, set on the first dropped trigger

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk.
  - In any cycle with reset high: ts, trig_num, fifo_count, overflow_count and error_overflow go to 0; the FIFO is flushed and tag_valid goes to 0.
  - Inputs presented in a reset cycle are ignored; a trigger in a reset cycle is lost.
  - Tag data outputs are don't-care while tag_valid=0.
- Timestamp counter (ts):
  - Increments by 1 every cycle and wraps from 2^TS_WIDTH-1 to 0.
  - reset_trig_timestamp in cycle N: the value used in cycle N is 0, and ts=1 in cycle N+1.
  - Effective timestamp in cycle N: ts_eff = reset_trig_timestamp ? 0 : ts.
- Trigger number (trig_num): holds the number of the last accepted trigger.
  - Base in cycle N: base = reset_trig_num ? 0 : trig_num.
  - On a trigger, the tag number is base+1, wrapping modulo 2^TNUM_WIDTH; trig_num then takes base+1.
  - With no trigger, trig_num takes base.
  - The first trigger after reset or after reset_trig_num is numbered 1.
  - A dropped trigger still increments trig_num, so the readout sees a gap in numbering.
- Tag contents: {base+1, ts_eff, fill_type}, all sampled in the trigger cycle.
  - A fill_type change in the same cycle as the trigger uses the input value of that cycle.
- FIFO:
  - Push when trigger=1 and (fifo_count<FIFO_DEPTH, or a pop occurs in the same cycle).
  - Pop when tag_valid=1 and tag_ready=1.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - A trigger into an empty FIFO in cycle N gives tag_valid=1 in cycle N+1, with that tag on the outputs (one-cycle latency).
  - Head outputs are stable while tag_valid=1 and tag_ready=0.
  - fifo_count is registered and reflects pushes/pops of the previous cycle.
- Overflow:
  - Overflow occurs when trigger=1, fifo_count=FIFO_DEPTH and there is no pop.
  - On overflow the tag is discarded, overflow_count increments (saturating at all-ones), and error_overflow is set and held until reset.
- Consumer handshake: tag_ready may be asserted at any time; it has no effect while tag_valid=0.

Test Plan:
- Triggers at cycles 10, 11, 20 after reset, with tag_ready=1 and fill_type=2'b01 → three tags with numbers 1, 2, 3, timestamps 10, 11, 20, fill type 1; each tag_valid appears one cycle after its trigger; error_overflow=0.
- reset_trig_num and trigger together after 5 prior triggers → tag number 1; the next trigger gives number 2. reset_trig_timestamp and trigger together at cycle 100 → timestamp 0; a trigger at cycle 103 → timestamp 3.
- tag_ready=0, 18 consecutive triggers with FIFO_DEPTH=16 → fifo_count=16; overflow_count=2; error_overflow=1; draining yields numbers 1..16; the next trigger gets number 19.
- FIFO full, trigger and pop in the same cycle → push accepted, fifo_count stays 16, overflow_count unchanged.
- TS_WIDTH=4 build, triggers at ts=15 and on the next cycle → timestamps 15 then 0. TNUM_WIDTH=4, 17 triggers → the 16th tag is numbered 0 and the 17th is numbered 1.
- reset asserted with 5 tags queued and a trigger in the same cycle → tag_valid=0 the next cycle, fifo_count=0, overflow_count=0, error_overflow=0; the next trigger gets number 1.
